// File: rtl/alu_multicycle_unit_if.sv
// Request/response bundle for alu_multicycle_unit.
// A request transfers on a rising edge where start_i & ready_o; valid_o pulses for one cycle when result_o/illegal_o are new.
interface alu_multicycle_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [9:0]       funct_i;
  logic [1:0]       ALUOp_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             illegal_o;

  modport master (
    output start_i, funct_i, ALUOp_i, src1_i, src2_i,
    input  ready_o, valid_o, result_o, zero_o, illegal_o
  );

  modport slave (
    input  start_i, funct_i, ALUOp_i, src1_i, src2_i,
    output ready_o, valid_o, result_o, zero_o, illegal_o
  );
endinterface

// File: rtl/alu_multicycle_unit.sv
// EX-stage ALU with built-in {funct7,funct3}/ALUOp decode and an iterative shift-add multiplier.
// Single-cycle ops have latency 1; MUL takes WIDTH/MUL_BPC iterations and holds ready_o low meanwhile.
module alu_multicycle_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_multicycle_unit_if.slave bus,
  output logic                 dbg_state_o
);
  localparam int SH_W = $clog2(WIDTH);
  localparam int K    = WIDTH / MUL_BPC;
  localparam int CW   = $clog2(K + 1);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SLL, OP_SRA, OP_MUL, OP_ILL
  } op_t;

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] partial;
  logic [CW-1:0]    cnt;
  logic             valid_q;
  logic             illegal_q;
  logic [SH_W-1:0]  shamt;
  logic             unused_aluop;

  assign shamt        = bus.src2_i[SH_W-1:0];
  assign unused_aluop = bus.ALUOp_i[1];

  // Anything not explicitly listed decodes to OP_ILL, never to MUL.
  always_comb begin
    op = OP_ILL;
    if (bus.ALUOp_i[0]) begin
      if (bus.funct_i[2:0] == 3'b000)           op = OP_ADD;
      else if (bus.funct_i == 10'b0100000_101)  op = OP_SRA;
    end else begin
      case (bus.funct_i)
        10'b0000000_111: op = OP_AND;
        10'b0000000_100: op = OP_XOR;
        10'b0000000_001: op = OP_SLL;
        10'b0000000_000: op = OP_ADD;
        10'b0100000_000: op = OP_SUB;
        10'b0000001_000: op = OP_MUL;
        default:         op = OP_ILL;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = bus.src1_i + bus.src2_i;
      OP_SUB:  alu_res = bus.src1_i - bus.src2_i;
      OP_AND:  alu_res = bus.src1_i & bus.src2_i;
      OP_XOR:  alu_res = bus.src1_i ^ bus.src2_i;
      OP_SLL:  alu_res = bus.src1_i << shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.src1_i) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Partial product for the MUL_BPC low multiplier bits of this iteration.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (mul_b[j]) partial = partial + (mul_a << j);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      result_q  <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            if (op == OP_MUL) begin
              mul_a <= bus.src1_i;
              mul_b <= bus.src2_i;
              acc   <= '0;
              cnt   <= CW'(K);
              state <= S_MUL;
            end else begin
              result_q  <= alu_res;
              illegal_q <= (op == OP_ILL);
              valid_q   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc   <= acc + partial;
          mul_a <= mul_a << MUL_BPC;
          mul_b <= mul_b >> MUL_BPC;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result_q  <= acc + partial;
            illegal_q <= 1'b0;
            valid_q   <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o   = (state == S_IDLE);
  assign bus.valid_o   = valid_q;
  assign bus.result_o  = result_q;
  assign bus.illegal_o = illegal_q;
  assign bus.zero_o    = (result_q == '0);
  assign dbg_state_o   = (state == S_MUL);
endmodule

// File: tb/tb_alu_multicycle_unit.sv
// Bench for alu_multicycle_unit: two instances (MUL_BPC=1 and 4) share stimulus; a cycle model checks both every cycle.
module tb_alu_multicycle_unit;
  localparam int W = 32;

  localparam logic [9:0] F_ADD  = 10'b0000000_000;
  localparam logic [9:0] F_SUB  = 10'b0100000_000;
  localparam logic [9:0] F_AND  = 10'b0000000_111;
  localparam logic [9:0] F_XOR  = 10'b0000000_100;
  localparam logic [9:0] F_SLL  = 10'b0000000_001;
  localparam logic [9:0] F_MUL  = 10'b0000001_000;
  localparam logic [9:0] F_SRAI = 10'b0100000_101;
  localparam logic [1:0] RT = 2'b10;
  localparam logic [1:0] IT = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [9:0]    funct = '0;
  logic [1:0]    aop = '0;
  logic [W-1:0]  src1 = '0;
  logic [W-1:0]  src2 = '0;
  logic          dbg1, dbg4;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  logic [W:0]    exp_q[$];

  alu_multicycle_unit_if #(.WIDTH(W)) bus1 ();
  alu_multicycle_unit_if #(.WIDTH(W)) bus4 ();

  assign bus1.start_i = start;  assign bus4.start_i = start;
  assign bus1.funct_i = funct;  assign bus4.funct_i = funct;
  assign bus1.ALUOp_i = aop;    assign bus4.ALUOp_i = aop;
  assign bus1.src1_i  = src1;   assign bus4.src1_i  = src1;
  assign bus1.src2_i  = src2;   assign bus4.src2_i  = src2;

  alu_multicycle_unit #(.WIDTH(W), .MUL_BPC(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1), .dbg_state_o(dbg1));
  alu_multicycle_unit #(.WIDTH(W), .MUL_BPC(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .bus(bus4), .dbg_state_o(dbg4));

  logic         rdy [2];
  logic         vld [2];
  logic [W-1:0] res_w [2];
  logic         ill_w [2];
  logic         zer_w [2];
  assign rdy[0] = bus1.ready_o;    assign rdy[1] = bus4.ready_o;
  assign vld[0] = bus1.valid_o;    assign vld[1] = bus4.valid_o;
  assign res_w[0] = bus1.result_o; assign res_w[1] = bus4.result_o;
  assign ill_w[0] = bus1.illegal_o; assign ill_w[1] = bus4.illegal_o;
  assign zer_w[0] = bus1.zero_o;   assign zer_w[1] = bus4.zero_o;

  // clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: operation semantics from the decode table, plain arithmetic.
  typedef struct packed {
    logic         mul;
    logic         ill;
    logic [W-1:0] res;
  } ref_t;

  function automatic ref_t ref_alu(input logic [9:0] f, input logic [1:0] ao,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
    ref_t r;
    logic [4:0] sh;
    sh = b[4:0];
    r.mul = 1'b0; r.ill = 1'b0; r.res = '0;
    if (ao[0]) begin
      if (f[2:0] == 3'b000)  r.res = a + b;
      else if (f == F_SRAI)  r.res = $unsigned($signed(a) >>> sh);
      else                   r.ill = 1'b1;
    end else begin
      case (f)
        F_AND:   r.res = a & b;
        F_XOR:   r.res = a ^ b;
        F_SLL:   r.res = a << sh;
        F_ADD:   r.res = a + b;
        F_SUB:   r.res = a - b;
        F_MUL:   begin r.mul = 1'b1; r.res = a * b; end
        default: r.ill = 1'b1;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input int u, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s unit%0d cyc%0d: got %h required %h", name, u, cyc, got, exp);
    end
  endtask

  // Per-unit model state; busy counts remaining not-ready cycles.
  int           busy [2] = '{0, 0};
  bit           vpend [2] = '{0, 0};
  logic [W-1:0] held [2] = '{'0, '0};
  logic [W-1:0] mres [2] = '{'0, '0};
  logic         ill_h [2] = '{1'b0, 1'b0};
  int           kk [2] = '{32, 8};
  bit           model_ok = 1'b0;

  always @(negedge clk) begin
    ref_t r;
    for (int u = 0; u < 2; u++) begin
      if (model_ok) begin
        chk("ready", u, 64'(rdy[u]), 64'(busy[u] == 0));
        chk("valid", u, 64'(vld[u]), 64'(vpend[u]));
        chk("result", u, 64'(res_w[u]), 64'(held[u]));
        chk("illegal", u, 64'(ill_w[u]), 64'(ill_h[u]));
        chk("zero", u, 64'(zer_w[u]), 64'(held[u] == '0));
      end
      vpend[u] = 1'b0;
      if (!rst) begin
        busy[u] = 0; held[u] = '0; ill_h[u] = 1'b0;
      end else if (busy[u] > 0) begin
        busy[u]--;
        if (busy[u] == 0) begin
          vpend[u] = 1'b1; held[u] = mres[u]; ill_h[u] = 1'b0;
        end
      end else if (start) begin
        r = ref_alu(funct, aop, src1, src2);
        if (r.mul) begin
          busy[u] = kk[u]; mres[u] = r.res;
        end else begin
          vpend[u] = 1'b1; held[u] = r.res; ill_h[u] = r.ill;
        end
      end
    end
    if (!rst) model_ok = 1'b1;
  end

  // driver tasks (called at posedge+#1)
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [9:0] f, input logic [1:0] ao,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; funct = f; aop = ao; src1 = a; src2 = b;
    sync();
  endtask

  task automatic wait_valid(input int u, input int exp_cyc, input string name);
    logic [W:0] e;
    bit seen;
    e = exp_q.pop_front();
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (vld[u]) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s unit%0d: got no valid_o required valid at cyc%0d", name, u, exp_cyc);
    end else begin
      chk({name, "_cycle"}, u, 64'(cyc), 64'(exp_cyc));
      chk({name, "_value"}, u, 64'({ill_w[u], res_w[u]}), 64'(e));
      chk({name, "_zero"}, u, 64'(zer_w[u]), 64'(e[W-1:0] == '0));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(rdy[0] && rdy[1]) && n < 60) begin @(negedge clk); n++; end
    chk("idle_timeout", 0, 64'(rdy[0] && rdy[1]), 64'(1));
    sync();
  endtask

  localparam int NV = 8;
  logic [9:0]   tv_f [NV] = '{F_XOR, 10'b1111111_000, 10'b0000000_101, 10'b0100000_111,
                              F_MUL, F_SUB, F_SLL, F_SRAI};
  logic [1:0]   tv_o [NV] = '{RT, IT, IT, RT, RT, RT, RT, IT};
  logic [W-1:0] tv_a [NV] = '{32'hA5A5_0000, 32'h7FFF_FFFF, 32'h1234_5678, 32'h0000_00FF,
                              32'h1234_5678, 32'h0000_0000, 32'hDEAD_BEEF, 32'h7000_0000};
  logic [W-1:0] tv_b [NV] = '{32'hFFFF_00FF, 32'h0000_0001, 32'h0000_0003, 32'h0000_000F,
                              32'h9ABC_DEF1, 32'h0000_0001, 32'h0000_001F, 32'h0000_001F};

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    sync();

    // ADD 5+7
    c = cyc;
    exp_q.push_back({1'b0, 32'h0000_000C});
    drive(F_ADD, RT, 32'd5, 32'd7); start = 1'b0;
    wait_valid(0, c + 1, "add");

    // SUB then AND back-to-back
    sync();
    c = cyc;
    exp_q.push_back({1'b0, 32'hFFFF_FFFE});
    exp_q.push_back({1'b0, 32'h0000_00F0});
    fork
      begin
        drive(F_SUB, RT, 32'd3, 32'd5);
        drive(F_AND, RT, 32'h0000_F0F0, 32'h0000_0FF0);
        start = 1'b0;
      end
      begin
        wait_valid(0, c + 1, "sub_b2b");
        wait_valid(0, c + 2, "and_b2b");
      end
    join

    // MUL 0xFFFFFFFF*3 on both units, with stray start pulses while unit0 is busy
    sync();
    c = cyc;
    exp_q.push_back({1'b0, 32'hFFFF_FFFD});
    drive(F_MUL, RT, 32'hFFFF_FFFF, 32'd3); start = 1'b0;
    wait_valid(1, c + 9, "mul_bpc4");
    sync();
    drive(F_ADD, RT, 32'd1, 32'd1); start = 1'b0;
    sync(); sync();
    drive(F_XOR, RT, 32'd6, 32'd3); start = 1'b0;
    exp_q.push_back({1'b0, 32'hFFFF_FFFD});
    wait_valid(0, c + 33, "mul_bpc1");
    wait_idle();

    // SRAI 0x80000000 by 4
    c = cyc;
    exp_q.push_back({1'b0, 32'hF800_0000});
    drive(F_SRAI, IT, 32'h8000_0000, 32'd4); start = 1'b0;
    wait_valid(0, c + 1, "srai");

    // SLL 1 by 0x21 (shamt masked)
    sync();
    c = cyc;
    exp_q.push_back({1'b0, 32'h0000_0002});
    drive(F_SLL, RT, 32'd1, 32'h21); start = 1'b0;
    wait_valid(0, c + 1, "sll_mask");

    // Undecodable R-type
    sync();
    c = cyc;
    exp_q.push_back({1'b1, 32'h0000_0000});
    drive(10'b0000001_111, RT, 32'h1234, 32'h5678); start = 1'b0;
    wait_valid(0, c + 1, "illegal");

    // Directed table, checked by the cycle model
    sync();
    for (int i = 0; i < NV; i++) begin
      drive(tv_f[i], tv_o[i], tv_a[i], tv_b[i]); start = 1'b0;
      wait_idle();
      sync();
    end

    // Reset in the middle of a MUL
    c = cyc;
    drive(F_MUL, RT, 32'h0000_0013, 32'h0000_0011); start = 1'b0;
    while (cyc < c + 10) sync();
    rst = 1'b0;
    sync();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 0, 64'(rdy[0]), 64'(1));
    chk("rst_result", 0, 64'(res_w[0]), 64'(0));
    repeat (40) sync();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
